dcc_wait_gen: RTL
=================

# dcc_wait_gen

Wait-state and DRAM-refresh sequencer placed directly downstream of the system-bus chip-select decoder. It consumes the decoded strobes ROMCE_N, SRAMCE_N, SMPCCE_N and DCE_N together with the SH-2 bus-cycle strobes. It drives the WAIT_N that the decoder currently ties high, inserting a per-region number of wait states and stretching SMPC accesses until the SMPC reports ready. It also arbitrates DRAM refresh against CPU DRAM accesses, so that decoded accesses complete with correct timing instead of zero-wait.

## Interface
- ROM_WS, default 4: wait ticks for ROM accesses (0–15).
- SRAM_WS, default 2: wait ticks for backup-SRAM accesses (0–15).
- DRAM_WS, default 1: wait ticks for DRAM accesses (0–15).
- SMPC_MIN_WS, default 2: minimum wait ticks for SMPC accesses (1–15).
- SMPC_TO, default 255: SMPC timeout in ticks (SMPC_MIN_WS+1 to 255).
- REF_LEN, default 3: refresh length in ticks (1–15).
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- CE_R  in  1  rising-phase clock enable. One "tick" is one CLK edge with CE_R=1. Only ticks advance state.
- BS_N  in  1  SH-2 bus-cycle start, active low.
- RD_N  in  1  read strobe, active low.
- WE_N  in  2  byte write strobes, active low.
- ROMCE_N, SRAMCE_N, SMPCCE_N, DCE_N  in  1 each  decoded selects, active low.
- SMPC_RDY  in  1  SMPC access-complete, active high.
- REF_REQ  in  1  DRAM refresh request (level).
- WAIT_N  out  1  registered wait to CPU, active low.
- REF_BUSY  out  1  high while a refresh is in progress.
- REF_ACK  out  1  one-tick pulse on the last refresh tick.
- SMPC_TIMEOUT  out  1  one-tick pulse when an SMPC wait times out.

## Operation
- Reset values: WAIT_N=1, REF_BUSY=0, REF_ACK=0, SMPC_TIMEOUT=0, state=IDLE, counters=0. RST dominates CE_R. Reset mid-access releases WAIT_N on the next CLK edge.
- Access start = tick in IDLE with BS_N=0 and at least one select low.
- Region priority when several selects are low: SMPC > DRAM > SRAM > ROM.
- States: IDLE, COUNT, SMPC, REFRESH, HOLD.
- IDLE, access start with N = region WS:
  - N>0: WAIT_N←0, cnt←N−1, go to COUNT.
  - N=0: go to HOLD, WAIT_N stays 1.
  - SMPC start: WAIT_N←0, cnt←SMPC_MIN_WS−1, to←SMPC_TO−1, go to SMPC.
- IDLE, no access start, REF_REQ=1: REF_BUSY←1, cnt←REF_LEN−1, go to REFRESH.
- Access start and REF_REQ on the same tick: the access wins. Refresh is taken on the first IDLE tick after the access.
- COUNT: each tick cnt−1. On the tick with cnt=0: WAIT_N←1, go to HOLD. WAIT_N is therefore low for exactly N ticks.
- SMPC: each tick, cnt saturates-decrements and to decrements.
  - Exit when cnt=0 and SMPC_RDY=1: WAIT_N←1, go to HOLD.
  - Exit when to=0 (SMPC_RDY still 0): WAIT_N←1, SMPC_TIMEOUT pulse for one tick, go to HOLD.
  - Both conditions true on the same tick: the ready path is taken, no timeout pulse.
- REFRESH: each tick cnt−1. On cnt=0: REF_ACK pulse, REF_BUSY←0.
  - If a DRAM access is pending: WAIT_N stays 0, cnt←DRAM_WS−1, go to COUNT. If DRAM_WS=0: WAIT_N←1, go to HOLD.
  - Otherwise go to IDLE.
- Access start during REFRESH:
  - DRAM select: latch a pending flag and drive WAIT_N←0 on that tick.
  - Non-DRAM select: handled as in IDLE, but only after refresh completes. WAIT_N←0 immediately while it waits.
- HOLD: stay until RD_N=1 and WE_N=2'b11 and all selects high, then go to IDLE. This prevents a single bus cycle from being counted twice.
- REF_REQ deasserted mid-refresh: the refresh still runs to completion.

## Timing
- WAIT_N is registered. It changes only on tick edges (or on RST), never combinationally.
- WAIT_N falls on the same tick edge that samples access start. Latency from start to WAIT_N low is therefore 0 ticks after the sampling edge.
- Outputs are valid one CLK after the edge, and are stable while CE_R=0.
- Minimum IDLE→IDLE turnaround for a 0-wait access is 2 ticks: start, then HOLD exit.
- SMPC wait length is max(SMPC_MIN_WS, ready tick) ticks, capped at SMPC_TO ticks.
- REF_BUSY is high for exactly REF_LEN ticks per refresh.

## Test plan
- ROM read, defaults, CE_R every cycle, BS_N low 1 tick → WAIT_N low exactly 4 ticks, then high. Returns to IDLE after RD_N rises.
- SRAM_WS=0 access → WAIT_N never low. FSM goes HOLD→IDLE when strobes release.
- SMPC read: SMPC_RDY rises on tick 6 → WAIT_N low 6 ticks, no SMPC_TIMEOUT. Repeat with SMPC_RDY held 0 → WAIT_N low 255 ticks, one SMPC_TIMEOUT pulse.
- REF_REQ=1 in IDLE, DRAM access starts 1 tick later → REF_BUSY high 3 ticks, REF_ACK at tick 3. WAIT_N low from the start tick through refresh end plus 1 DRAM tick.
- REF_REQ and ROM start on the same tick → ROM gets 4 waits first. REF_BUSY rises on the first IDLE tick after HOLD.
- RST asserted on the 2nd wait tick of a ROM access → next edge: WAIT_N=1, REF_BUSY=0, state IDLE. CE_R toggling every 2nd cycle doubles all wall-clock durations.

Source files
------------

// File: rtl/dcc_wait_gen.sv
// Wait-state and DRAM-refresh sequencer behind the bus chip-select decoder.
// Drives WAIT_N per region, stretches SMPC accesses and arbitrates refresh.
module dcc_wait_gen #(
   parameter int unsigned ROM_WS      = 4,
   parameter int unsigned SRAM_WS     = 2,
   parameter int unsigned DRAM_WS     = 1,
   parameter int unsigned SMPC_MIN_WS = 2,
   parameter int unsigned SMPC_TO     = 255,
   parameter int unsigned REF_LEN     = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE_R,
   input  logic       BS_N,
   input  logic       RD_N,
   input  logic [1:0] WE_N,
   input  logic       ROMCE_N,
   input  logic       SRAMCE_N,
   input  logic       SMPCCE_N,
   input  logic       DCE_N,
   input  logic       SMPC_RDY,
   input  logic       REF_REQ,
   output logic       WAIT_N,
   output logic       REF_BUSY,
   output logic       REF_ACK,
   output logic       SMPC_TIMEOUT
);

   typedef enum logic [2:0] {IDLE, COUNT, SMPC, REFRESH, HOLD} state_t;
   typedef enum logic [1:0] {RGN_ROM, RGN_SRAM, RGN_DRAM, RGN_SMPC} rgn_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] to_q, to_d;
   logic       wait_n_q, wait_n_d;
   logic       ref_busy_q, ref_busy_d;
   logic       ref_ack_q, ref_ack_d;
   logic       smpc_to_q, smpc_to_d;
   logic       pend_q, pend_d;
   rgn_t       pend_rgn_q, pend_rgn_d;

   logic       start_c, release_c, launch_wait_n_c;
   rgn_t       start_rgn_c, launch_rgn_c;
   state_t     launch_state_c;
   logic [3:0] launch_cnt_c;

   function automatic logic [3:0] ws_of(rgn_t r);
      case (r)
         RGN_ROM:  return 4'(ROM_WS);
         RGN_SRAM: return 4'(SRAM_WS);
         RGN_DRAM: return 4'(DRAM_WS);
         default:  return 4'(SMPC_MIN_WS);
      endcase
   endfunction

   // Access decode; launch_* describes how a (possibly deferred) access begins.
   always_comb begin
      start_c   = !BS_N && (!ROMCE_N || !SRAMCE_N || !SMPCCE_N || !DCE_N);
      release_c = RD_N && (WE_N == 2'b11) && ROMCE_N && SRAMCE_N && SMPCCE_N && DCE_N;
      if (!SMPCCE_N)      start_rgn_c = RGN_SMPC;
      else if (!DCE_N)    start_rgn_c = RGN_DRAM;
      else if (!SRAMCE_N) start_rgn_c = RGN_SRAM;
      else                start_rgn_c = RGN_ROM;
      launch_rgn_c = (state_q == REFRESH && pend_q) ? pend_rgn_q : start_rgn_c;
      launch_cnt_c = ws_of(launch_rgn_c) - 4'd1;
      if (launch_rgn_c == RGN_SMPC)           launch_state_c = SMPC;
      else if (ws_of(launch_rgn_c) == 4'd0)   launch_state_c = HOLD;
      else                                    launch_state_c = COUNT;
      launch_wait_n_c = (launch_state_c == HOLD);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         to_q       <= 8'd0;
         wait_n_q   <= 1'b1;
         ref_busy_q <= 1'b0;
         ref_ack_q  <= 1'b0;
         smpc_to_q  <= 1'b0;
         pend_q     <= 1'b0;
         pend_rgn_q <= RGN_ROM;
      end else if (CE_R) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         to_q       <= to_d;
         wait_n_q   <= wait_n_d;
         ref_busy_q <= ref_busy_d;
         ref_ack_q  <= ref_ack_d;
         smpc_to_q  <= smpc_to_d;
         pend_q     <= pend_d;
         pend_rgn_q <= pend_rgn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_c)      state_d = launch_state_c;
            else if (REF_REQ) state_d = REFRESH;
         end
         COUNT:   if (cnt_q == 4'd0) state_d = HOLD;
         SMPC:    if ((cnt_q == 4'd0 && SMPC_RDY) || to_q == 8'd0) state_d = HOLD;
         REFRESH: if (cnt_q == 4'd0) state_d = (pend_q || start_c) ? launch_state_c : IDLE;
         HOLD:    if (release_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters, pending access and registered outputs.
   always_comb begin
      cnt_d      = cnt_q;
      to_d       = to_q;
      wait_n_d   = wait_n_q;
      ref_busy_d = ref_busy_q;
      ref_ack_d  = 1'b0;
      smpc_to_d  = 1'b0;
      pend_d     = pend_q;
      pend_rgn_d = pend_rgn_q;
      case (state_q)
         IDLE: begin
            if (start_c) begin
               cnt_d    = launch_cnt_c;
               to_d     = 8'(SMPC_TO - 1);
               wait_n_d = launch_wait_n_c;
            end else if (REF_REQ) begin
               ref_busy_d = 1'b1;
               cnt_d      = 4'(REF_LEN - 1);
               pend_d     = 1'b0;
            end
         end
         COUNT: begin
            if (cnt_q == 4'd0) wait_n_d = 1'b1;
            else               cnt_d    = cnt_q - 4'd1;
         end
         SMPC: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            if (to_q != 8'd0)  to_d  = to_q - 8'd1;
            if (cnt_q == 4'd0 && SMPC_RDY) begin
               wait_n_d = 1'b1;
            end else if (to_q == 8'd0) begin
               wait_n_d  = 1'b1;
               smpc_to_d = 1'b1;
            end
         end
         REFRESH: begin
            if (!pend_q && start_c) begin
               pend_d     = 1'b1;
               pend_rgn_d = start_rgn_c;
               wait_n_d   = 1'b0;
            end
            if (cnt_q == 4'd0) begin
               ref_ack_d  = 1'b1;
               ref_busy_d = 1'b0;
               pend_d     = 1'b0;
               if (pend_q || start_c) begin
                  cnt_d    = launch_cnt_c;
                  to_d     = 8'(SMPC_TO - 1);
                  wait_n_d = launch_wait_n_c;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: ;
      endcase
   end

   assign WAIT_N       = wait_n_q;
   assign REF_BUSY     = ref_busy_q;
   assign REF_ACK      = ref_ack_q;
   assign SMPC_TIMEOUT = smpc_to_q;

endmodule
